// File: rtl/npu_matmul_unit.sv
// npu_matmul_unit: N x N matrix multiply, C = A x B, one multiply-accumulate per cycle.
// Each result element is formed over N MAC cycles, post-processed (ReLU, then narrowing),
// and offered on a valid/ready stream in row-major order.
module npu_matmul_unit #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      cmd_ready,
  input  logic                      mode_signed,
  input  logic                      mode_relu,
  input  logic                      mode_sat,
  input  logic [N*N*DATA_W-1:0]     a_flat,
  input  logic [N*N*DATA_W-1:0]     b_flat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(N*N)-1:0]    out_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf,
  output logic [31:0]               op_count,
  output logic [31:0]               cycle_count
);

  localparam int IW = $clog2(N);
  localparam int OW = $clog2(N * N);
  localparam int MW = N * N * DATA_W;
  localparam int SW = $clog2(MW);

  localparam logic signed [ACC_W-1:0] SMax = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMin = ACC_W'(-(2 ** (DATA_W - 1)));
  localparam logic signed [ACC_W-1:0] UMax = ACC_W'((2 ** DATA_W) - 1);

  typedef enum logic [1:0] {StIdle, StMac, StEmit, StDone} state_t;

  state_t state_q, state_d;

  logic [MW-1:0]            a_q, b_q;
  logic                     signed_q, relu_q, sat_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [IW-1:0]            r_q, c_q, k_q;

  logic [SW-1:0]            a_bit, b_bit;
  logic [DATA_W-1:0]        a_el, b_el;
  logic signed [DATA_W:0]   a_ext, b_ext;
  logic signed [2*DATA_W+1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum, relu_val;
  logic                     hi, lo, oor;
  logic [DATA_W-1:0]        narrow, max_el, min_el;
  logic [OW-1:0]            idx_cur;
  logic                     k_last, last_elem;

  // Operand fetch, MAC arithmetic and result post-processing
  always_comb begin
    a_bit   = SW'((SW'(r_q) * SW'(N) + SW'(k_q)) * SW'(DATA_W));
    b_bit   = SW'((SW'(k_q) * SW'(N) + SW'(c_q)) * SW'(DATA_W));
    a_el    = a_q[a_bit +: DATA_W];
    b_el    = b_q[b_bit +: DATA_W];
    // One extra bit lets a single signed multiplier serve both modes
    a_ext   = {signed_q & a_el[DATA_W-1], a_el};
    b_ext   = {signed_q & b_el[DATA_W-1], b_el};
    prod    = a_ext * b_ext;
    acc_sum = acc_q + ACC_W'(prod);

    relu_val = acc_sum;
    if (signed_q && relu_q && (acc_sum < 0)) relu_val = '0;

    if (signed_q) begin
      hi     = relu_val > SMax;
      lo     = relu_val < SMin;
      max_el = {1'b0, {(DATA_W-1){1'b1}}};
      min_el = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      hi     = relu_val > UMax;
      lo     = 1'b0;
      max_el = '1;
      min_el = '0;
    end
    oor    = hi | lo;
    narrow = relu_val[DATA_W-1:0];
    if (sat_q) begin
      if (hi)      narrow = max_el;
      else if (lo) narrow = min_el;
    end

    idx_cur   = OW'(OW'(r_q) * OW'(N) + OW'(c_q));
    k_last    = (k_q == IW'(N - 1));
    last_elem = (r_q == IW'(N - 1)) && (c_q == IW'(N - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state and status outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (start) state_d = StMac;
      end
      StMac:  if (k_last) state_d = StEmit;
      StEmit: if (out_ready) state_d = last_elem ? StDone : StMac;
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath, result registers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      relu_q      <= 1'b0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      ovf         <= 1'b0;
      op_count    <= '0;
      cycle_count <= '0;
    end else begin
      if (busy) cycle_count <= cycle_count + 32'd1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= a_flat;
            b_q      <= b_flat;
            signed_q <= mode_signed;
            relu_q   <= mode_relu;
            sat_q    <= mode_sat;
            acc_q    <= '0;
            r_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            ovf      <= 1'b0;
            op_count <= op_count + 32'd1;
          end
        end
        StMac: begin
          acc_q <= acc_sum;
          if (k_last) begin
            out_data  <= narrow;
            out_idx   <= idx_cur;
            out_valid <= 1'b1;
            if (oor) ovf <= 1'b1;
          end else begin
            k_q <= k_q + IW'(1);
          end
        end
        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_q     <= '0;
            k_q       <= '0;
            if (c_q == IW'(N - 1)) begin
              c_q <= '0;
              r_q <= r_q + IW'(1);
            end else begin
              c_q <= c_q + IW'(1);
            end
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_matmul_unit.sv
// Directed bench for npu_matmul_unit (N=4, DATA_W=8, ACC_W=20).
module tb_npu_matmul_unit;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 20;
  localparam int NE = N * N;
  localparam int MW = NE * W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              cmd_ready;
  logic              mode_signed, mode_relu, mode_sat;
  logic [MW-1:0]     a_flat, b_flat;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [3:0]        out_idx;
  logic              busy, done, ovf;
  logic [31:0]       op_count, cycle_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  got_data [NE];
  logic [3:0]    got_idx  [NE];
  int            n_got, first_valid, done_cyc, unstable, stall_seen;
  logic          ovf_c1, ovf_end, ovf_pre;
  logic [31:0]   ops_end, cc_delta;
  logic          post_ready, post_busy, post_done;
  logic [MW-1:0] mat_i, mat_seq, mat_ff, mat_02;

  always #5 clk = ~clk;

  npu_matmul_unit #(.N(N), .DATA_W(W), .ACC_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmd_ready   (cmd_ready),
    .mode_signed (mode_signed),
    .mode_relu   (mode_relu),
    .mode_sat    (mode_sat),
    .a_flat      (a_flat),
    .b_flat      (b_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf),
    .op_count    (op_count),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it cycle by cycle (cycle 1 = first cycle after acceptance).
  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input logic s, input logic relu, input logic sat,
                        input int stall, input int pulse_at, input int rst_at);
    int cyc;
    int stall_left;
    logic [31:0] cc0;
    logic [W-1:0] hold_data;
    logic [3:0] hold_idx;
    n_got = 0; first_valid = -1; done_cyc = -1; unstable = 0;
    stall_left = stall; hold_data = '0; hold_idx = '0;
    @(negedge clk);
    a_flat = a; b_flat = b; mode_signed = s; mode_relu = relu; mode_sat = sat;
    start = 1'b1; out_ready = 1'b1;
    cc0 = cycle_count;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (cyc == 1) ovf_c1 = ovf;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == rst_at) begin
        ovf_pre = ovf;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stall_seen = stall - stall_left;
        return;
      end
      if (cyc == pulse_at) begin
        start = 1'b1;
        a_flat = '1;
      end else begin
        start = 1'b0;
      end
      out_ready = 1'b1;
      if (out_valid && out_idx == 4'd3 && stall_left > 0) begin
        if (stall_left == stall) begin
          hold_data = out_data;
          hold_idx  = out_idx;
        end else if (out_data !== hold_data || out_idx !== hold_idx) begin
          unstable++;
        end
        out_ready = 1'b0;
        stall_left--;
      end
      if (out_valid && out_ready && n_got < NE) begin
        got_data[n_got] = out_data;
        got_idx[n_got]  = out_idx;
        n_got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    stall_seen = stall - stall_left;
    ovf_end = ovf;
    ops_end = op_count;
    @(posedge clk); #1;
    post_ready = cmd_ready;
    post_busy  = busy;
    post_done  = done;
    cc_delta   = cycle_count - cc0;
  endtask

  // ident=1: expect 1..16 (A = I, B = 1..16); otherwise every element equals k.
  task automatic chk_elems(input bit ident, input logic [W-1:0] k);
    chk("elem_count", 32'(n_got), 32'(NE));
    for (int i = 0; i < n_got; i++) begin
      chk("elem_data", 32'(got_data[i]), ident ? 32'(i + 1) : 32'(k));
      chk("elem_idx", 32'(got_idx[i]), 32'(i));
    end
  endtask

  initial begin
    mat_i = '0;
    for (int i = 0; i < N; i++) mat_i[(i * N + i) * W +: W] = 8'd1;
    for (int i = 0; i < NE; i++) begin
      mat_seq[i * W +: W] = W'(i + 1);
      mat_02[i * W +: W]  = 8'h02;
    end
    mat_ff = '1;

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    mode_signed = 1'b0; mode_relu = 1'b0; mode_sat = 1'b0;
    a_flat = '0; b_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    @(posedge clk); #1;
    chk("idle_cycle_count", cycle_count, 32'd0);

    // Identity, unsigned
    run_op(mat_i, mat_seq, 1'b0, 1'b0, 1'b1, 0, -1, -1);
    chk_elems(1'b1, 8'h00);
    chk("id_first_valid", 32'(first_valid), 32'd5);
    chk("id_done_cycle", 32'(done_cyc), 32'd81);
    chk("id_ovf", 32'(ovf_end), 32'd0);
    chk("id_op_count", ops_end, 32'd1);
    chk("id_cycle_delta", cc_delta, 32'd81);
    chk("id_post_ready", 32'(post_ready), 32'd1);
    chk("id_post_busy", 32'(post_busy), 32'd0);
    chk("id_done_pulse", 32'(post_done), 32'd0);

    // Signed, -1 x 2 summed over 4 terms
    run_op(mat_ff, mat_02, 1'b1, 1'b0, 1'b1, 0, -1, -1);
    chk_elems(1'b0, 8'hF8);
    chk("sgn_ovf", 32'(ovf_end), 32'd0);
    chk("sgn_op_count", ops_end, 32'd2);

    run_op(mat_ff, mat_02, 1'b1, 1'b1, 1'b1, 0, -1, -1);
    chk_elems(1'b0, 8'h00);
    chk("relu_ovf", 32'(ovf_end), 32'd0);

    // Unsigned 4 * 255 * 255 = 0x3F804
    run_op(mat_ff, mat_ff, 1'b0, 1'b0, 1'b1, 0, -1, -1);
    chk_elems(1'b0, 8'hFF);
    chk("sat_ovf", 32'(ovf_end), 32'd1);

    run_op(mat_ff, mat_ff, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    chk_elems(1'b0, 8'h04);
    chk("trunc_ovf", 32'(ovf_end), 32'd1);

    run_op(mat_i, mat_seq, 1'b0, 1'b0, 1'b1, 0, -1, -1);
    chk_elems(1'b1, 8'h00);
    chk("clr_ovf_c1", 32'(ovf_c1), 32'd0);
    chk("clr_ovf_end", 32'(ovf_end), 32'd0);
    chk("clr_op_count", ops_end, 32'd6);

    // Backpressure on element 3
    run_op(mat_i, mat_seq, 1'b0, 1'b0, 1'b1, 5, -1, -1);
    chk_elems(1'b1, 8'h00);
    chk("bp_stall_cycles", 32'(stall_seen), 32'd5);
    chk("bp_unstable", 32'(unstable), 32'd0);
    chk("bp_done_cycle", 32'(done_cyc), 32'd86);
    chk("bp_cycle_delta", cc_delta, 32'd86);

    // Start pulse while busy, with different A
    run_op(mat_i, mat_seq, 1'b0, 1'b0, 1'b1, 0, 2, -1);
    chk_elems(1'b1, 8'h00);
    chk("busy_start_ops", ops_end, 32'd8);
    chk("busy_start_done", 32'(done_cyc), 32'd81);

    // Reset in cycle 30 of an overflowing op
    run_op(mat_ff, mat_ff, 1'b0, 1'b0, 1'b0, 0, -1, 30);
    chk("mid_ovf_before", 32'(ovf_pre), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_data", 32'(out_data), 32'd0);
    chk("mid_out_idx", 32'(out_idx), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    chk("mid_op_count", op_count, 32'd0);
    chk("mid_cycle_count", cycle_count, 32'd0);

    run_op(mat_i, mat_seq, 1'b0, 1'b0, 1'b1, 0, -1, -1);
    chk_elems(1'b1, 8'h00);
    chk("fresh_done_cycle", 32'(done_cyc), 32'd81);
    chk("fresh_op_count", ops_end, 32'd1);
    chk("fresh_ovf", 32'(ovf_end), 32'd0);
    chk("fresh_cycle_delta", cc_delta, 32'd81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_matmul_unit.md
# npu_matmul_unit

Parametrised N×N matrix-multiply engine for the neural-network accelerator path. It computes C = A × B with one multiply-accumulate per cycle and a selectable signed or unsigned mode. Optional ReLU and saturating narrowing are applied to each result. Results stream out row-major over a valid/ready handshake, with a sticky overflow flag and performance counters. It sits beside the CPU datapath as the matrix-multiply workhorse of the accelerator.

## Interface
- N, 4: matrix dimension; legal values are 2 to 8.
- DATA_W, 8: operand and result element width.
- ACC_W, 20: accumulator width; must be ≥ 2·DATA_W + clog2(N) + 1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only when cmd_ready=1.
- cmd_ready  out  1  high in IDLE.
- mode_signed  in  1  operands and results are two's complement; latched at start.
- mode_relu  in  1  negative accumulations become 0; latched at start.
- mode_sat  in  1  1 = clamp result, 0 = truncate to the low DATA_W bits; latched at start.
- a_flat  in  N·N·DATA_W  matrix A, row-major; element [r][k] is at bits (r·N+k)·DATA_W upward.
- b_flat  in  N·N·DATA_W  matrix B, same packing; latched at start.
- out_valid  out  1  result element available.
- out_ready  in  1  consumer accepts the element.
- out_data  out  DATA_W  result element.
- out_idx  out  clog2(N·N)  row-major index r·N+c.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last element is accepted.
- ovf  out  1  sticky: some element was clamped or truncated out of range in the current operation.
- op_count  out  32  commands accepted; wraps.
- cycle_count  out  32  cycles with busy=1; wraps.

## Operation
- States: IDLE, MAC, EMIT, DONE.
- IDLE
  - start=1: latch A, B and the mode bits; clear acc, r, c, k and ovf; increment op_count; go to MAC.
- MAC
  - Each cycle: acc ← acc + A[r][k]·B[k][c], then k increments.
  - Products are sign-extended when mode_signed=1, zero-extended otherwise, then extended to ACC_W.
  - After the k=N−1 term, register the post-processed result into out_data and out_idx, assert out_valid, go to EMIT.
- Post-processing order:
  - First ReLU: if mode_relu and acc < 0 (signed mode only), the value becomes 0.
  - Then narrowing to DATA_W.
  - Clamp range is −2^(DATA_W−1) to 2^(DATA_W−1)−1 when signed, 0 to 2^DATA_W−1 when unsigned.
  - An out-of-range value sets ovf in both saturating and truncating modes.
- EMIT
  - out_valid holds; out_data and out_idx stay stable until out_valid·out_ready.
  - On the handshake, clear acc and k, and advance c (wrapping to 0 with r+1).
  - If it was the last element (idx = N·N−1), go to DONE; otherwise go to MAC.
- DONE: done=1 for one cycle, then IDLE.
- start while busy: ignored, no side effects.
- out_ready while out_valid=0: ignored.
- Reset mid-operation: on the next edge, state = IDLE and all outputs return to reset values. The partial result is discarded.

## Timing
- Reset values:
  - cmd_ready=1 (combinational from state IDLE).
  - out_valid=0, out_data=0, out_idx=0, busy=0, done=0, ovf=0.
  - op_count=0, cycle_count=0.
- Start is accepted at edge T0.
- MAC occupies cycles T1 to TN; out_valid first rises in cycle T(N+1).
- With out_ready held at 1, each element takes N+1 cycles.
  - The last handshake completes at the edge ending cycle T0+N·N·(N+1).
  - done is high in the following cycle.
  - For N=4: out_valid first at cycle 5, done at cycle 81, next start accepted at cycle 82.
- Each cycle of out_ready=0 during EMIT delays done by exactly one cycle.
- cycle_count increments on every edge where busy=1, including DONE.
- busy falls in the same cycle cmd_ready rises.

## Test plan
- Identity: N=4, unsigned, A=I, B=1..16, out_ready=1.
  - Expect out_data 1..16 with out_idx 0..15 in order.
  - First out_valid at cycle 5, done at cycle 81, ovf=0, op_count=1.
- Signed with ReLU: A all 0xFF (−1), B all 0x02, mode_signed=1.
  - mode_relu=0: every element is 0xF8 (−8).
  - mode_relu=1: every element is 0x00; ovf=0 in both cases.
- Saturation: unsigned, A and B all 0xFF.
  - mode_sat=1: every element is 0xFF, ovf=1.
  - mode_sat=0: 260100 = 0x3F804, so every element is 0x04, ovf=1.
  - A following start with small operands clears ovf.
- Backpressure: out_ready is 0 for 5 cycles while element 3 is valid.
  - out_data and out_idx stay stable throughout.
  - done moves from cycle 81 to cycle 86.
  - cycle_count delta is 86.
- Start while busy: pulse start during MAC with different A.
  - The results are unchanged and op_count does not increment.
- Reset mid-op: assert rst in cycle 30.
  - Next cycle: busy=0, out_valid=0, ovf=0, counters=0.
  - A fresh identity run then completes correctly.
